// File: rtl/gate_check_pipe.sv
// Gate-result checker: captures the selected upstream gate output, compares it against an
// internally computed golden value and queues the result in a 2-entry FIFO with error stats.
module gate_check_pipe #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic [6:0]       in_res,
  input  logic [2:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [2:0]       out_sel,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_any
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } occ_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  occ_e             occ_q;
  logic [1:0]       bit_q;
  logic [1:0]       err_q;
  logic [2:0]       sel_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic             rdy_en_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             err_any_q;

  logic             push;
  logic             pop;
  logic             golden;
  logic             new_bit;
  logic             new_err;
  logic [7:0]       res_ext;

  always_comb begin
    golden = 1'b0;
    case (in_sel)
      3'd0:    golden = in_a & in_b;
      3'd1:    golden = in_a | in_b;
      3'd2:    golden = ~in_a;
      3'd3:    golden = ~(in_a & in_b);
      3'd4:    golden = ~(in_a | in_b);
      3'd5:    golden = in_a ^ in_b;
      3'd6:    golden = ~(in_a ^ in_b);
      default: golden = 1'b0;
    endcase
  end

  // Select 7 has no gate behind it: stored as bit 0 and always flagged.
  assign res_ext = {1'b0, in_res};

  always_comb begin
    new_bit = 1'b0;
    new_err = 1'b1;
    if (in_sel != 3'd7) begin
      new_bit = res_ext[in_sel];
      new_err = (new_bit != golden);
    end
  end

  // rdy_en_q holds in_ready low until the first edge after reset release.
  assign in_ready  = rdy_en_q && (occ_q != StFull);
  assign out_valid = (occ_q != StEmpty);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_bit = out_valid ? bit_q[rd_ptr_q] : 1'b0;
  assign out_sel = out_valid ? sel_q[rd_ptr_q] : 3'd0;
  assign out_err = out_valid ? err_q[rd_ptr_q] : 1'b0;
  assign err_cnt = err_cnt_q;
  assign err_any = err_any_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= StEmpty;
      bit_q     <= 2'b00;
      err_q     <= 2'b00;
      sel_q[0]  <= 3'd0;
      sel_q[1]  <= 3'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      rdy_en_q  <= 1'b0;
      err_cnt_q <= '0;
      err_any_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) begin
        bit_q[wr_ptr_q] <= new_bit;
        err_q[wr_ptr_q] <= new_err;
        sel_q[wr_ptr_q] <= in_sel;
        wr_ptr_q        <= ~wr_ptr_q;
        if (new_err) begin
          err_any_q <= 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CntOne;
        end
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (push && !pop) begin
        occ_q <= (occ_q == StEmpty) ? StOne : StFull;
      end else if (pop && !push) begin
        occ_q <= (occ_q == StFull) ? StOne : StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_gate_check_pipe.sv
// Bench for gate_check_pipe: queue-based reference model checked every cycle, plus literal
// expectations on directed scenarios. A second instance with CNT_W=2 covers saturation.
module tb_gate_check_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_a;
  logic       in_b;
  logic [6:0] in_res;
  logic [2:0] in_sel;
  logic       out_ready;

  logic       in_ready, out_valid, out_bit, out_err, err_any;
  logic [2:0] out_sel;
  logic [7:0] err_cnt;

  logic       in_ready2, out_valid2, out_bit2, out_err2, err_any2;
  logic [2:0] out_sel2;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  gate_check_pipe #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_res(in_res), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_sel(out_sel),
    .out_err(out_err), .err_cnt(err_cnt), .err_any(err_any)
  );

  gate_check_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_res(in_res), .in_sel(in_sel),
    .out_valid(out_valid2), .out_ready(out_ready), .out_bit(out_bit2), .out_sel(out_sel2),
    .out_err(out_err2), .err_cnt(err_cnt2), .err_any(err_any2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Truth table of every gate, bit order as on in_res.
  function automatic logic [6:0] all_gates(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  typedef struct {
    logic       b;
    logic [2:0] sel;
    logic       err;
  } entry_t;

  entry_t m_q[$];
  bit     m_rdy_en = 0;
  int     m_errs = 0;
  bit     m_any = 0;

  always @(negedge rst_n) begin
    m_q.delete();
    m_rdy_en = 0;
    m_errs = 0;
    m_any = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      entry_t e;
      bit do_push, do_pop;
      logic [6:0] ref_res;
      do_push = in_valid && m_rdy_en && (m_q.size() < 2);
      do_pop  = out_ready && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        ref_res = all_gates(in_a, in_b);
        e.sel = in_sel;
        if (in_sel == 3'd7) begin
          e.b = 1'b0;
          e.err = 1'b1;
        end else begin
          e.b = in_res[in_sel];
          e.err = (e.b != ref_res[in_sel]);
        end
        if (e.err) begin
          m_errs++;
          m_any = 1;
        end
        m_q.push_back(e);
      end
      m_rdy_en = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit v;
      v = (m_q.size() > 0);
      chk("in_ready", int'(in_ready), int'(m_rdy_en && m_q.size() < 2));
      chk("out_valid", int'(out_valid), int'(v));
      chk("out_bit", int'(out_bit), v ? int'(m_q[0].b) : 0);
      chk("out_sel", int'(out_sel), v ? int'(m_q[0].sel) : 0);
      chk("out_err", int'(out_err), v ? int'(m_q[0].err) : 0);
      chk("err_cnt", int'(err_cnt), (m_errs > 255) ? 255 : m_errs);
      chk("err_any", int'(err_any), int'(m_any));
      chk("err_cnt_w2", int'(err_cnt2), (m_errs > 3) ? 3 : m_errs);
      chk("out_valid_w2", int'(out_valid2), int'(v));
    end
  end

  task automatic step(input logic v, input logic a, input logic b, input logic [6:0] res,
                      input logic [2:0] sel, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_res    = res;
    in_sel    = sel;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_a = 1'b0;
    in_b = 1'b0;
    in_res = 7'd0;
    in_sel = 3'd0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    #2 rst_n = 1'b1;

    step(0, 0, 0, 7'd0, 3'd0, 1);
    chk("ready_after_rst", int'(in_ready), 1);

    // Single transfer: XOR of (1,0) is 1; bit4 of the vector is wrong but not selected.
    step(1, 1, 0, 7'b0111010, 3'd5, 1);
    chk("single_valid", int'(out_valid), 1);
    chk("single_bit", int'(out_bit), 1);
    chk("single_err", int'(out_err), 0);
    chk("single_cnt", int'(err_cnt), 0);
    step(0, 0, 0, 7'd0, 3'd0, 1);
    chk("single_drained", int'(out_valid), 0);

    // Fill and stall, then a push attempt while full must not bypass.
    step(1, 0, 1, all_gates(0, 1), 3'd0, 0);
    step(1, 0, 1, all_gates(0, 1), 3'd1, 0);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_head_sel", int'(out_sel), 0);
    step(0, 0, 0, 7'd0, 3'd0, 0);
    chk("stall_head_sel", int'(out_sel), 0);
    step(1, 1, 1, all_gates(1, 1), 3'd3, 1);
    chk("second_sel", int'(out_sel), 1);
    chk("second_bit", int'(out_bit), 1);
    step(0, 0, 0, 7'd0, 3'd0, 1);
    chk("no_bypass", int'(out_valid), 0);

    // Error detection, then a correct sample with simultaneous push/pop.
    step(1, 1, 1, all_gates(1, 1) & 7'b1111110, 3'd0, 1);
    chk("err_out_err", int'(out_err), 1);
    chk("err_cnt1", int'(err_cnt), 1);
    chk("err_any1", int'(err_any), 1);
    step(1, 0, 1, all_gates(0, 1), 3'd5, 1);
    chk("ok_out_err", int'(out_err), 0);
    chk("ok_out_bit", int'(out_bit), 1);
    chk("sticky_any", int'(err_any), 1);

    // Illegal select.
    step(1, 1, 0, 7'h7f, 3'd7, 1);
    chk("ill_bit", int'(out_bit), 0);
    chk("ill_err", int'(out_err), 1);
    chk("ill_cnt", int'(err_cnt), 2);

    // Three more errors: five total, narrow counter saturates at 3.
    for (int i = 0; i < 3; i++) step(1, i[0], 1, 7'h00, 3'd7, 1);
    chk("cnt5", int'(err_cnt), 5);
    chk("sat_cnt", int'(err_cnt2), 3);

    // Mixed traffic exercised against the model.
    for (int i = 0; i < 60; i++) begin
      logic a, b;
      logic [6:0] r;
      a = 1'($urandom);
      b = 1'($urandom);
      r = all_gates(a, b) ^ (($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0);
      step(1'($urandom), a, b, r, 3'($urandom), 1'($urandom));
    end

    // Reset while full: everything clears without a clock edge.
    step(0, 0, 0, 7'd0, 3'd0, 1);
    step(0, 0, 0, 7'd0, 3'd0, 1);
    step(1, 1, 1, 7'h00, 3'd7, 0);
    step(1, 1, 1, all_gates(1, 1), 3'd2, 0);
    chk("prefull_ready", int'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", int'(out_valid), 0);
    chk("async_cnt", int'(err_cnt), 0);
    chk("async_any", int'(err_any), 0);
    chk("async_ready", int'(in_ready), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", int'(in_ready), 1);
    chk("rel_valid", int'(out_valid), 0);
    step(1, 0, 0, all_gates(0, 0), 3'd6, 1);
    chk("post_rst_bit", int'(out_bit), 1);
    step(0, 0, 0, 7'd0, 3'd0, 1);

    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_check_pipe.md
GATE_CHECK_PIPE -- requirements
Module: gate_check_pipe

Interface
REQ-001 Parameter CNT_W, default 8: width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset: asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream has a result sample to deliver.
REQ-005 in_ready  output  1  block can accept a sample this cycle.
REQ-006 in_a, in_b  input  1 each  operands applied to the upstream gate stage.
REQ-007 in_res  input  7  gate outputs from upstream: bit0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
REQ-008 in_sel  input  3  index of the gate result to forward (0-6 legal, 7 illegal).
REQ-009 out_valid  output  1  head entry is available downstream.
REQ-010 out_ready  input  1  downstream accepts the head entry.
REQ-011 out_bit  output  1  selected gate result of the head entry.
REQ-012 out_sel  output  3  in_sel captured with the head entry.
REQ-013 out_err  output  1  head entry failed its golden check.
REQ-014 err_cnt  output  CNT_W  saturating count of accepted erroneous samples.
REQ-015 err_any  output  1  sticky flag, set by the first accepted erroneous sample.

Function
REQ-016 Push SHALL occur only when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-017 Pop SHALL occur only when out_valid=1 and out_ready=1 at a rising clk edge.
REQ-018 Storage SHALL be a 2-entry FIFO with occupancy states EMPTY(0), ONE(1) and FULL(2).
REQ-019 Occupancy transitions: push only -> +1; pop only -> -1; push and pop together -> unchanged (legal in ONE only).
REQ-020 in_ready SHALL equal 1 in EMPTY and ONE and 0 in FULL; there is no bypass when full, even if out_ready=1.
REQ-021 out_valid SHALL equal 1 exactly when occupancy is not EMPTY.
REQ-022 Latency: a sample pushed at edge N SHALL appear on out_* after edge N if the FIFO was empty; there is no combinational path from in_* to out_*.
REQ-023 Each pushed entry SHALL store: bit = in_res[in_sel], sel = in_sel, err = (bit != golden), all taken from the push cycle.
REQ-024 The golden value SHALL be computed internally from in_a and in_b for the gate indexed by in_sel, using the gate encoding in REQ-007.
REQ-025 For in_sel=7, the entry SHALL store bit=0 and err=1.
REQ-026 out_bit, out_sel and out_err SHALL present the oldest entry and remain stable while out_valid=1 and out_ready=0.
REQ-027 Entries SHALL be delivered in push order; read and write pointers wrap modulo 2.
REQ-028 err_cnt SHALL increment by 1 on each push with err=1 and saturate at 2^CNT_W-1.
REQ-029 err_any SHALL set on the first push with err=1 and clear only on reset.
REQ-030 out_bit, out_sel and out_err SHALL be 0 whenever out_valid=0.

Reset
REQ-031 While rst_n=0, the block SHALL force: occupancy EMPTY, pointers 0, in_ready=0, out_valid=0, out_bit=0, out_sel=0, out_err=0, err_cnt=0, err_any=0.
REQ-032 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all stored entries immediately; no partial push or pop SHALL survive.

Verification
REQ-034 Single transfer: a=1, b=0, sel=5, in_res=7'b0111010, out_ready=1 -> next cycle out_valid=1, out_bit=1, out_err=0, err_cnt=0.
REQ-035 Fill and stall: out_ready=0, push sel=0 then sel=1 -> in_ready=0 after the second push; out_sel holds 0; raising out_ready delivers sel=0 then sel=1.
REQ-036 Error detection: a=1, b=1, sel=0, in_res bit0=0 -> out_err=1, err_cnt=1, err_any=1; then a legal, correct sample -> err_any stays 1.
REQ-037 Illegal select: sel=7 with any operands -> out_bit=0, out_err=1, err_cnt increments.
REQ-038 Saturation: CNT_W=2, push 5 erroneous samples -> err_cnt=3.
REQ-039 Reset mid-operation: FIFO FULL, assert rst_n=0 -> out_valid=0 and err_cnt=0 immediately, without waiting for a clk edge; after release, in_ready=1 on the next edge.
